fpga_uart_harness: RTL

- UART-controlled stimulus/response harness for the FPGA bring-up top. Replaces hard-tied scan-chain fields and the raw RX->TX loopback.
- Receives 8N1 command bytes on RX and drives these registers:
  - project index
  - project inputs
  - scan-machine mode
  - debug-clock bit
- Returns sampled project outputs on TX, either on request or automatically when they change.
- Sits between the board pins and user_project_wrapper io_in/io_out.

---
 rtl/fpga_harness_pkg.sv | 31 +++
 rtl/uart_8n1.sv | 119 +++++++++++
 rtl/fpga_uart_harness.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/fpga_harness_pkg.sv
// Shared opcodes, reset constants and state encodings for the UART bring-up harness.
package fpga_harness_pkg;

    localparam logic [7:0] OP_INPUTS = 8'h49;
    localparam logic [7:0] OP_INDEX  = 8'h50;
    localparam logic [7:0] OP_MODE   = 8'h4D;
    localparam logic [7:0] OP_READ   = 8'h52;
    localparam logic [7:0] OP_CLEAR  = 8'h43;

    localparam logic [1:0] SCAN_MODE_RESET = 2'b10;

    typedef enum logic [1:0] {
        DEC_IDLE,
        DEC_ARG1,
        DEC_ARG2
    } dec_state_t;

    typedef enum logic [1:0] {
        TGT_INPUTS,
        TGT_INDEX,
        TGT_MODE
    } arg_target_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_8n1.sv
// 8N1 UART receive and transmit engines sharing one bit period of DIV clocks.
module uart_8n1
    import fpga_harness_pkg::*;
#(
    parameter int DIV = 104
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_frame_err,
    output logic       tx_busy,
    output logic       tx
);

    localparam int CW = $clog2(DIV) + 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

    logic          rx_meta, rx_sync, rx_prev;
    rx_state_t     rx_state, rx_next;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          half_hit, bit_hit;

    logic [9:0]    tx_shift;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;

    assign half_hit = (rx_cnt == HALF_LAST);
    assign bit_hit  = (rx_cnt == BIT_LAST);
    assign rx_data  = rx_shift;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (reset) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
        end else begin
            rx_meta  <= rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_state <= rx_next;
        end
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_sync) rx_next = RX_START;
            RX_START: if (half_hit) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_hit && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (bit_hit) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_shift     <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            if (rx_state == RX_IDLE || rx_next != rx_state || (rx_state != RX_START && bit_hit))
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + 1'b1;
            if (rx_state == RX_START)
                rx_bit <= '0;
            if (rx_state == RX_DATA && bit_hit) begin
                rx_shift <= {rx_sync, rx_shift[7:1]};
                rx_bit   <= rx_bit + 1'b1;
            end
            if (rx_state == RX_STOP && bit_hit) begin
                rx_valid     <= rx_sync;
                rx_frame_err <= !rx_sync;
            end
        end
    end

    // Frame is shifted out LSB first; ones shift in so the line rests high.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_busy  <= 1'b0;
            tx_shift <= '1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
        end else if (!tx_busy) begin
            if (tx_start) begin
                tx_shift <= {1'b1, tx_data, 1'b0};
                tx_busy  <= 1'b1;
                tx_cnt   <= '0;
                tx_bit   <= '0;
            end
        end else if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_shift <= {1'b1, tx_shift[9:1]};
            if (tx_bit == 4'd9)
                tx_busy <= 1'b0;
            else
                tx_bit <= tx_bit + 1'b1;
        end else begin
            tx_cnt <= tx_cnt + 1'b1;
        end
    end

    assign tx = tx_busy ? tx_shift[0] : 1'b1;

endmodule

// File: rtl/fpga_uart_harness.sv
// UART command decoder driving project selection/inputs and reporting project outputs on TX.
module fpga_uart_harness
    import fpga_harness_pkg::*;
#(
    parameter int CLK_HZ      = 12000000,
    parameter int BAUD        = 115200,
    parameter int IN_W        = 8,
    parameter int OUT_W       = 8,
    parameter int IDX_W       = 9,
    parameter int TIMEOUT_CYC = 1200000
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             RX,
    output logic             TX,
    input  logic [OUT_W-1:0] io_out_i,
    input  logic             ready_i,
    output logic [IN_W-1:0]  proj_inputs,
    output logic [IDX_W-1:0] proj_index,
    output logic [1:0]       scan_mode,
    output logic             dbg_clk,
    output logic             err_led,
    output logic             act_led
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    logic             rx_valid, rx_frame_err, tx_start, tx_busy;
    logic [7:0]       rx_data;

    dec_state_t       state, next_state;
    arg_target_t      target, next_target;
    logic [TW-1:0]    to_cnt;
    logic             timeout;
    logic             wr_inputs, wr_index, wr_mode, cap_lo;
    logic             rd_req, clr_err, set_err, accept;
    logic [7:0]       idx_lo;
    logic [15:0]      idx_full;
    logic             auto_en;

    logic [OUT_W-1:0] io_meta, io_sync, last_rep;
    logic             rdy_meta, rdy_sync;
    logic [7:0]       rpt_byte, pend_data;
    logic             rpt_req, pend_valid;

    uart_8n1 #(.DIV(DIV)) u_uart (
        .clk          (CLK),
        .reset        (RESET),
        .rx           (RX),
        .tx_start     (tx_start),
        .tx_data      (pend_data),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_frame_err (rx_frame_err),
        .tx_busy      (tx_busy),
        .tx           (TX)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= DEC_IDLE;
            target <= TGT_INPUTS;
            to_cnt <= '0;
        end else begin
            state  <= next_state;
            target <= next_target;
            to_cnt <= (rx_valid || state == DEC_IDLE) ? '0 : to_cnt + 1'b1;
        end
    end

    assign timeout = (state != DEC_IDLE) && (to_cnt == TO_LAST);

    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        next_state  = state;
        next_target = target;
        wr_inputs   = 1'b0;
        wr_index    = 1'b0;
        wr_mode     = 1'b0;
        cap_lo      = 1'b0;
        rd_req      = 1'b0;
        clr_err     = 1'b0;
        set_err     = 1'b0;
        accept      = 1'b0;
        case (state)
            DEC_IDLE: if (rx_valid) begin
                case (rx_data)
                    OP_INPUTS: begin next_state = DEC_ARG1; next_target = TGT_INPUTS; end
                    OP_INDEX:  begin next_state = DEC_ARG1; next_target = TGT_INDEX;  end
                    OP_MODE:   begin next_state = DEC_ARG1; next_target = TGT_MODE;   end
                    OP_READ:   begin rd_req  = 1'b1; accept = 1'b1; end
                    OP_CLEAR:  begin clr_err = 1'b1; accept = 1'b1; end
                    default:   set_err = 1'b1;
                endcase
            end
            DEC_ARG1: if (rx_valid) begin
                if (target == TGT_INDEX) begin
                    cap_lo     = 1'b1;
                    next_state = DEC_ARG2;
                end else begin
                    wr_inputs  = (target == TGT_INPUTS);
                    wr_mode    = (target == TGT_MODE);
                    accept     = 1'b1;
                    next_state = DEC_IDLE;
                end
            end else if (timeout) begin
                set_err    = 1'b1;
                next_state = DEC_IDLE;
            end
            DEC_ARG2: if (rx_valid) begin
                wr_index   = 1'b1;
                accept     = 1'b1;
                next_state = DEC_IDLE;
            end else if (timeout) begin
                set_err    = 1'b1;
                next_state = DEC_IDLE;
            end
            default: next_state = DEC_IDLE;
        endcase
    end

    assign idx_full = {rx_data, idx_lo};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            proj_inputs <= '0;
            proj_index  <= '0;
            scan_mode   <= SCAN_MODE_RESET;
            dbg_clk     <= 1'b0;
            auto_en     <= 1'b0;
            idx_lo      <= '0;
            err_led     <= 1'b0;
            act_led     <= 1'b0;
        end else begin
            if (wr_inputs) proj_inputs <= rx_data[IN_W-1:0];
            if (cap_lo)    idx_lo      <= rx_data;
            if (wr_index)  proj_index  <= idx_full[IDX_W-1:0];
            if (wr_mode) begin
                scan_mode <= rx_data[1:0];
                dbg_clk   <= rx_data[2];
                auto_en   <= rx_data[3];
            end
            if (set_err || rx_frame_err) err_led <= 1'b1;
            else if (clr_err)            err_led <= 1'b0;
            if (accept) act_led <= !act_led;
        end
    end

    always_comb begin
        rpt_byte = '0;
        rpt_byte[OUT_W-1:0] = io_sync;
        if (OUT_W < 8) rpt_byte[7] = rdy_sync;
    end

    assign rpt_req  = rd_req || (auto_en && io_sync != last_rep);
    assign tx_start = pend_valid && !tx_busy;

    // While auto-report is off the baseline tracks the outputs, so enabling it never fires on stale history.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            io_meta    <= '0;
            io_sync    <= '0;
            rdy_meta   <= 1'b0;
            rdy_sync   <= 1'b0;
            last_rep   <= '0;
            pend_valid <= 1'b0;
            pend_data  <= '0;
        end else begin
            io_meta  <= io_out_i;
            io_sync  <= io_meta;
            rdy_meta <= ready_i;
            rdy_sync <= rdy_meta;
            if (rpt_req || !auto_en) last_rep <= io_sync;
            if (rpt_req) begin
                pend_valid <= 1'b1;
                pend_data  <= rpt_byte;
            end else if (tx_start) begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule
